issue_scoreboard: RTL and testbench

- Parametrised issue/hazard controller for the next-generation processor pipeline.
- Replaces ad-hoc stall/divFlag/mulStall wiring with a per-register busy scoreboard and a writeback reservation shift register.
- Decodes the 16-bit opcode, holds instructions on RAW, WAW, structural or writeback-port conflicts, and generates writeback strobes at configurable per-class latencies.
- Sits between instruction memory and the register file/ALU.

---
 rtl/issue_scoreboard.sv | 136 +++++++++++++
 tb/tb_issue_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue/hazard controller: decodes opcodes, holds on RAW/WAW/unit/writeback-port
// conflicts and retires results through a latency-indexed reservation shift register.
module issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int RAW      = 4,
  parameter int LAT_ALU  = 1,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ins_valid,
  input  logic [15:0]         ins_opcode,
  output logic                ins_ready,
  input  logic                flush,
  output logic                issue_valid,
  output logic [3:0]          issue_op,
  output logic [RAW-1:0]      issue_src1,
  output logic [RAW-1:0]      issue_src2,
  output logic [RAW-1:0]      issue_dst,
  output logic                issue_wide,
  output logic                wb_valid,
  output logic [RAW-1:0]      wb_dst,
  output logic                wb_wide,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                unit_busy
);

  localparam int LW = $clog2(LAT_DIV + 1);
  localparam int IW = (LAT_DIV > 1) ? $clog2(LAT_DIV) : 1;

  logic [3:0]          opField;
  logic                isNop, isImm, isMul, isDiv, isUnit, readsSrc;
  logic [RAW-1:0]      src1, src2, dst, dstHi, wbDstHi;
  logic [LW-1:0]       lat;
  logic [IW-1:0]       latIdx;
  logic [NUM_REGS-1:0] srcMask, dstMask, wbMask;
  logic                rawHit, wawHit, unitHit, slotHit, doIssue;

  logic [LAT_DIV-1:0]          resValid, resWide, resValidNxt, resWideNxt;
  logic [LAT_DIV-1:0][RAW-1:0] resDst, resDstNxt;
  logic [LAT_DIV:0]            resValidExt;

  always_comb begin
    opField  = ins_opcode[15:12];
    isNop    = (opField == 4'd15);
    isImm    = (opField == 4'd4) || (opField == 4'd5);
    isMul    = (opField == 4'd6);
    isDiv    = (opField == 4'd7);
    isUnit   = isMul || isDiv;
    readsSrc = !isNop && !isImm;
    src1     = RAW'(ins_opcode[11:8]);
    src2     = RAW'(ins_opcode[7:4]);
    dst      = isImm ? RAW'(ins_opcode[11:8]) : RAW'(ins_opcode[3:0]);
    dstHi    = dst + RAW'(1);
    lat      = isDiv ? LW'(LAT_DIV) : (isMul ? LW'(LAT_MUL) : LW'(LAT_ALU));
    latIdx   = IW'(lat - LW'(1));
  end

  always_comb begin
    srcMask = (NUM_REGS'(1) << src1) | (NUM_REGS'(1) << src2);
    dstMask = (NUM_REGS'(1) << dst) | (isUnit ? (NUM_REGS'(1) << dstHi) : '0);
    wbDstHi = wb_dst + RAW'(1);
    wbMask  = '0;
    if (wb_valid) begin
      wbMask = (NUM_REGS'(1) << wb_dst) | (wb_wide ? (NUM_REGS'(1) << wbDstHi) : '0);
    end
  end

  // An occupant at index lat lands on lat-1 after the shift, colliding with this issue.
  assign resValidExt = {1'b0, resValid};

  always_comb begin
    rawHit  = readsSrc && (|(busy_mask & srcMask));
    wawHit  = |(busy_mask & dstMask);
    unitHit = isUnit && unit_busy;
    slotHit = resValidExt[lat];
    ins_ready = !flush && (isNop || !(rawHit || wawHit || unitHit || slotHit));
  end

  assign issue_valid = ins_valid && ins_ready;
  assign doIssue     = issue_valid && !isNop;
  assign issue_op    = opField;
  assign issue_src1  = src1;
  assign issue_src2  = src2;
  assign issue_dst   = dst;
  assign issue_wide  = isUnit;

  always_comb begin
    resValidNxt = resValid >> 1;
    resWideNxt  = resWide >> 1;
    resDstNxt   = resDst >> RAW;
    if (doIssue) begin
      resValidNxt[latIdx] = 1'b1;
      resWideNxt[latIdx]  = isUnit;
      resDstNxt[latIdx]   = dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resValid  <= '0;
      resWide   <= '0;
      resDst    <= '0;
      busy_mask <= '0;
      unit_busy <= 1'b0;
      wb_valid  <= 1'b0;
      wb_dst    <= '0;
      wb_wide   <= 1'b0;
    end else if (flush) begin
      resValid  <= '0;
      resWide   <= '0;
      resDst    <= '0;
      busy_mask <= '0;
      unit_busy <= 1'b0;
      wb_valid  <= 1'b0;
      wb_dst    <= '0;
      wb_wide   <= 1'b0;
    end else begin
      resValid  <= resValidNxt;
      resWide   <= resWideNxt;
      resDst    <= resDstNxt;
      wb_valid  <= resValid[0];
      wb_dst    <= resValid[0] ? resDst[0] : '0;
      wb_wide   <= resValid[0] && resWide[0];
      busy_mask <= (busy_mask & ~wbMask) | (doIssue ? dstMask : '0);
      // Only MUL/DIV are wide, so a wide entry reaching index 0 is the unit op retiring.
      if (doIssue && isUnit) begin
        unit_busy <= 1'b1;
      end else if (resValid[0] && resWide[0]) begin
        unit_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed steps then held-until-issued random traffic,
// checked each cycle against a list of pending writebacks keyed by absolute edge number.
module tb_issue_scoreboard;
  localparam int LA = 1;
  localparam int LM = 4;
  localparam int LD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic [15:0] ins_opcode = 16'hF000;
  logic        flush = 1'b0;
  logic        ins_ready, issue_valid, issue_wide, wb_valid, wb_wide, unit_busy;
  logic [3:0]  issue_op, issue_src1, issue_src2, issue_dst, wb_dst;
  logic [15:0] busy_mask;

  issue_scoreboard #(.NUM_REGS(16), .RAW(4), .LAT_ALU(LA), .LAT_MUL(LM), .LAT_DIV(LD)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_opcode(ins_opcode),
    .ins_ready(ins_ready), .flush(flush), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_src1(issue_src1), .issue_src2(issue_src2), .issue_dst(issue_dst),
    .issue_wide(issue_wide), .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_wide(wb_wide),
    .busy_mask(busy_mask), .unit_busy(unit_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wbEdge;
    int dst;
    bit wide;
    bit unit;
  } pendT;

  pendT pend[$];
  int   now = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic int latOf(input logic [3:0] op);
    if (op == 4'd6) return LM;
    if (op == 4'd7) return LD;
    return LA;
  endfunction

  function automatic bit isWide(input logic [3:0] op);
    return (op == 4'd6) || (op == 4'd7);
  endfunction

  function automatic int dstOf(input logic [15:0] o);
    if (o[15:12] == 4'd4 || o[15:12] == 4'd5) return int'(o[11:8]);
    return int'(o[3:0]);
  endfunction

  function automatic bit regBusy(input int r);
    foreach (pend[i]) begin
      if (now <= pend[i].wbEdge &&
          (pend[i].dst == r || (pend[i].wide && ((pend[i].dst + 1) % 16) == r)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit unitBusy();
    foreach (pend[i]) if (pend[i].unit && now < pend[i].wbEdge) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit expReady(input logic [15:0] o, input logic f);
    logic [3:0] op;
    int d;
    op = o[15:12];
    if (f) return 1'b0;
    if (op == 4'd15) return 1'b1;
    if (op != 4'd4 && op != 4'd5 && (regBusy(int'(o[11:8])) || regBusy(int'(o[7:4]))))
      return 1'b0;
    d = dstOf(o);
    if (regBusy(d) || (isWide(op) && regBusy((d + 1) % 16))) return 1'b0;
    if (isWide(op) && unitBusy()) return 1'b0;
    foreach (pend[i]) if (pend[i].wbEdge == now + 1 + latOf(op)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkCycle();
    bit          r;
    logic [15:0] bm;
    bit          wv, ww;
    int          wd;
    r = expReady(ins_opcode, flush);
    chk("ins_ready", ins_ready, r);
    chk("issue_valid", issue_valid, ins_valid & r);
    if (ins_valid && r) begin
      chk("issue_op", issue_op, ins_opcode[15:12]);
      chk("issue_src1", issue_src1, ins_opcode[11:8]);
      chk("issue_src2", issue_src2, ins_opcode[7:4]);
      chk("issue_dst", issue_dst, dstOf(ins_opcode));
      chk("issue_wide", issue_wide, isWide(ins_opcode[15:12]));
    end
    bm = '0;
    for (int k = 0; k < 16; k++) bm[k] = regBusy(k);
    chk("busy_mask", busy_mask, bm);
    chk("unit_busy", unit_busy, unitBusy());
    wv = 0; ww = 0; wd = 0;
    foreach (pend[i]) begin
      if (pend[i].wbEdge == now) begin
        wv = 1; wd = pend[i].dst; ww = pend[i].wide;
      end
    end
    chk("wb_valid", wb_valid, wv);
    chk("wb_dst", wb_dst, wd);
    chk("wb_wide", wb_wide, ww);
  endtask

  task automatic step(input logic v, input logic [15:0] o, input logic f, output bit iss);
    bit r;
    ins_valid = v; ins_opcode = o; flush = f;
    @(negedge clk);
    checkCycle();
    r = expReady(o, f);
    iss = v && r;
    @(posedge clk);
    now++;
    if (f) pend.delete();
    else if (iss && o[15:12] != 4'd15)
      pend.push_back('{now + latOf(o[15:12]), dstOf(o), isWide(o[15:12]), isWide(o[15:12])});
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].wbEdge < now) pend.delete(i);
    #1;
  endtask

  task automatic idle(input int n);
    bit d;
    repeat (n) step(1'b0, 16'hF000, 1'b0, d);
  endtask

  task automatic offer(input logic [15:0] o);
    bit iss;
    int n;
    iss = 0; n = 0;
    while (!iss && n < 40) begin
      step(1'b1, o, 1'b0, iss);
      n++;
    end
    ins_valid = 1'b0;
  endtask

  task automatic midReset();
    ins_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_mask", busy_mask, 16'h0000);
    chk("rst_unit_busy", unit_busy, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    pend.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    now++;
    #1;
  endtask

  initial begin
    bit          iss;
    logic [15:0] op;
    logic [3:0]  f1, f2, f3;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("init_busy_mask", busy_mask, 16'h0000);
    chk("init_unit_busy", unit_busy, 1'b0);
    chk("init_wb_valid", wb_valid, 1'b0);
    chk("init_wb_dst", wb_dst, 4'd0);
    chk("init_wb_wide", wb_wide, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    now++;
    #1;

    // Pending DIV discarded by reset, then an ALU op issues immediately
    offer(16'h7560);
    idle(3);
    midReset();
    offer(16'h0123);
    idle(20);

    // RAW on r3
    offer(16'h0123);
    offer(16'h0345);
    idle(3);

    // MUL, then ALU colliding on the writeback port, then DIV waiting for the unit
    offer(16'h6124);
    idle(2);
    offer(16'h0189);
    offer(16'h7560);
    idle(20);

    // Immediate ignores sources; wide DIV wraps r15 onto r0
    offer(16'h4A00);
    offer(16'h700F);
    idle(20);

    // Flush kills an in-flight DIV; a MUL follows right away
    offer(16'h7ABC);
    idle(4);
    step(1'b1, 16'hF000, 1'b1, iss);
    offer(16'h6124);
    idle(8);

    // WAW on the upper half of a MUL pair
    offer(16'h6124);
    offer(16'h0125);
    idle(8);

    // Random traffic: each instruction is held until accepted, occasional flushes
    op = 16'hF000;
    iss = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) midReset();
      if (iss) begin
        f1 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        f2 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        f3 = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        op = {4'($urandom_range(0, 15)), f1, f2, f3};
      end
      if ($urandom_range(0, 4) == 0) begin
        step(1'b0, op, ($urandom_range(0, 31) == 0), iss);
        iss = 1'b0;
      end else begin
        step(1'b1, op, ($urandom_range(0, 31) == 0), iss);
      end
    end
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
